// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair for MULT/MULTU/DIV/DIVU
// and MFHI/MFLO/MTHI/MTLO. Multiply is radix-2 shift-add, divide is restoring;
// both share one 2*WIDTH accumulator and finish with a sign-fixup state.
// Optional macro MDU_EARLY_TERM_EN: multiply exits as soon as the remaining
// multiplier bits are all zero.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_out
);

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;      // mul: {partial product, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]   opnd_q;     // mul: multiplicand magnitude; div: divisor magnitude
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_res_q;  // product / quotient must be negated
  logic               neg_rem_q;  // remainder (or raw dividend) must be negated
  logic               div_zero_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [CNT_W-1:0]   cnt_inc;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_acc;
  logic               mul_last;

  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MDU_EARLY_TERM_EN
  logic [WIDTH-1:0]   mul_left;
  logic [CNT_W-1:0]   mul_shamt;
`endif

  // Operand magnitudes and sign bits for the op being presented.
  always_comb begin
    is_signed = ~funct[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  // One shift-add multiply step, plus the exit decision.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_EARLY_TERM_EN
    // Unconsumed multiplier bits sit below the cnt+1 product bits already shifted in.
    mul_left  = mul_next[WIDTH-1:0] << cnt_inc;
    mul_shamt = LastIter - cnt_q;
    mul_last  = (cnt_q == LastIter) || (mul_left == '0);
    mul_acc   = mul_next >> mul_shamt;
`else
    mul_last  = (cnt_q == LastIter);
    mul_acc   = mul_next;
`endif
  end

  // One restoring-division step: shift in the next dividend bit, try subtract.
  always_comb begin
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fixup of the finished magnitude result.
  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        // Dividend magnitude is still untouched in the low half; restore raw a.
        fix_lo = '1;
        fix_hi = neg_rem_q ? -quo : quo;
      end else begin
        fix_lo = neg_res_q ? -quo : quo;
        fix_hi = neg_rem_q ? -rem : rem;
      end
    end
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            case (funct)
              FnMult, FnMultu: begin
                state_q    <= StMul;
                busy_q     <= 1'b1;
                is_div_q   <= 1'b0;
                acc_q      <= {{WIDTH{1'b0}}, mag_b};
                opnd_q     <= mag_a;
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                cnt_q      <= '0;
                div_zero_q <= 1'b0;
`ifdef MDU_EARLY_TERM_EN
                if (mag_b == '0) state_q <= StFix;
`endif
              end
              FnDiv, FnDivu: begin
                busy_q     <= 1'b1;
                is_div_q   <= 1'b1;
                acc_q      <= {{WIDTH{1'b0}}, mag_a};
                opnd_q     <= mag_b;
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                cnt_q      <= '0;
                div_zero_q <= (b == '0);
                state_q    <= (b == '0) ? StFix : StDiv;
              end
              FnMthi: begin
                hi_q   <= a;
                done_q <= 1'b1;
              end
              FnMtlo: begin
                lo_q   <= a;
                done_q <= 1'b1;
              end
              FnMfhi, FnMflo: begin
                // Reads are served combinationally on mf_out.
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        StMul: begin
          acc_q <= mul_acc;
          cnt_q <= cnt_inc;
          if (mul_last) state_q <= StFix;
        end
        StDiv: begin
          acc_q <= div_next;
          cnt_q <= cnt_inc;
          if (cnt_q == LastIter) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // MFHI/MFLO read mux.
  always_comb begin
    mf_out = '0;
    if (funct == FnMfhi) mf_out = hi_q;
    else if (funct == FnMflo) mf_out = lo_q;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
